// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// master = operand source and result sink, slave = the adder pipeline.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: STAGES registered carry segments of BLOCK-bit groups.
// Define CLA_STATUS_EN to build the registered signed-overflow and zero flags.
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    cla_pipe_addsub_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;
    localparam int GPS = SEG / BLOCK;

    // One lookahead group: every carry is a flat sum of products of g/p terms and ci.
    function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             ci);
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic             term;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            term = ci;
            for (int m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    function automatic logic [SEG:0] cla_segment(input logic [SEG-1:0] x,
                                                 input logic [SEG-1:0] y,
                                                 input logic           ci);
        logic [SEG-1:0] s;
        logic [BLOCK:0] r;
        logic           c;
        s = '0;
        c = ci;
        for (int gi = 0; gi < GPS; gi++) begin
            r = cla_group(x[gi*BLOCK +: BLOCK], y[gi*BLOCK +: BLOCK], c);
            s[gi*BLOCK +: BLOCK] = r[BLOCK-1:0];
            c = r[BLOCK];
        end
        return {c, s};
    endfunction

    logic [STAGES-1:0] v_d, v_q;
    logic [STAGES-1:0] en;

    // en[k]: stage k register may load this cycle (empty, or its contents move on).
    always_comb begin
        en = '0;
        en[STAGES-1] = !v_q[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) en[k] = !v_q[k] || en[k+1];
    end

    always_comb begin
        v_d = v_q;
        if (en[0]) v_d[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            if (en[k]) v_d[k] = v_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) v_q <= '0;
        else     v_q <= v_d;
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = v_q[STAGES-1];

`ifdef CLA_STATUS_EN
    logic ovf_d, ovf_q, zero_d, zero_q;
`endif

    // Stage k consumes operand segment k; acc carries finished sum bits below it and
    // unprocessed A bits above it, rem_b the B' bits still to be consumed.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SEG;
        localparam int SRC = WIDTH - LO;

        logic             src_v;
        logic [WIDTH-1:0] src_acc;
        logic [SRC-1:0]   src_b;
        logic             src_c;
        logic [SEG:0]     seg_res;
        logic             ld;
        logic [WIDTH-1:0] acc_d, acc_q;
        logic             c_d, c_q;

        if (k == 0) begin : g_head
            assign src_v   = bus.in_valid;
            assign src_acc = bus.a;
            assign src_b   = bus.sub ? ~bus.b : bus.b;
            assign src_c   = bus.sub ^ bus.cin;
        end else begin : g_link
            assign src_v   = v_q[k-1];
            assign src_acc = g_stage[k-1].acc_q;
            assign src_b   = g_stage[k-1].g_rem.rem_b_q;
            assign src_c   = g_stage[k-1].c_q;
        end

        assign seg_res = cla_segment(src_acc[LO +: SEG], src_b[SEG-1:0], src_c);
        assign ld      = en[k] && src_v;

        // NOTE: _d defaults to _q before the load branch so no path leaves it unassigned (no latch).
        always_comb begin
            acc_d = acc_q;
            c_d   = c_q;
            if (ld) begin
                acc_d            = src_acc;
                acc_d[LO +: SEG] = seg_res[SEG-1:0];
                c_d              = seg_res[SEG];
            end
        end

        // NOTE: datapath flops are reset too, so sum/cout read 0 straight after reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
                c_q   <= 1'b0;
            end else begin
                acc_q <= acc_d;
                c_q   <= c_d;
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [SRC-SEG-1:0] rem_b_d, rem_b_q;

            always_comb begin
                rem_b_d = rem_b_q;
                if (ld) rem_b_d = src_b[SRC-1:SEG];
            end

            always_ff @(posedge clk) begin
                if (rst) rem_b_q <= '0;
                else     rem_b_q <= rem_b_d;
            end
        end

`ifdef CLA_STATUS_EN
        if (k == STAGES - 1) begin : g_flags
            // src_acc MSB is still operand A here; src_b MSB is B'.
            always_comb begin
                ovf_d  = ovf_q;
                zero_d = zero_q;
                if (ld) begin
                    ovf_d  = (src_acc[WIDTH-1] == src_b[SRC-1]) &&
                             (acc_d[WIDTH-1] != src_acc[WIDTH-1]);
                    zero_d = ~|acc_d;
                end
            end
        end
`endif
    end

    assign bus.sum  = g_stage[STAGES-1].acc_q;
    assign bus.cout = g_stage[STAGES-1].c_q;

`ifdef CLA_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif
endmodule
